// File: rtl/mux_canal_scanner.sv
// rtl/mux_canal_scanner.sv - mux select sequencer with per-channel capture and hold/park mode
// Optional: define SCAN_GRAY_SEL_EN to drive o_sel as Gray(ch) instead of binary ch.
module mux_canal_scanner #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_hold,
  input  logic [SEL_W-1:0] i_hold_ch,
  input  logic             i_mux_s,
  output logic [SEL_W-1:0] o_sel,
  output logic [N_CH-1:0]  o_sample,
  output logic             o_frame_done,
  output logic             o_busy
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_ch;
  logic [CNT_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_sel;
  logic [N_CH-1:0]    r_sample;
  logic               r_frame_done;
  logic               r_busy;

  logic [SEL_W-1:0]   w_hold_ch;
  logic [SEL_W-1:0]   w_ch_next;
  logic               w_dwell_end;

  // Channel index stays binary; only the select encoding changes between builds.
  function automatic logic [SEL_W-1:0] to_sel(input logic [SEL_W-1:0] ch);
`ifdef SCAN_GRAY_SEL_EN
    return ch ^ (ch >> 1);
`else
    return ch;
`endif
  endfunction

  assign w_hold_ch   = (i_hold_ch > LAST_CH) ? LAST_CH : i_hold_ch;
  assign w_ch_next   = (r_ch == LAST_CH) ? '0 : r_ch + SEL_W'(1);
  assign w_dwell_end = (r_cnt == LAST_CNT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_ch         <= '0;
      r_cnt        <= '0;
      r_sel        <= '0;
      r_sample     <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_hold) begin
            r_state <= S_HOLD;
            r_ch    <= w_hold_ch;
            r_cnt   <= '0;
            r_sel   <= to_sel(w_hold_ch);
            r_busy  <= 1'b1;
          end else if (i_enable) begin
            r_state <= S_SCAN;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_sel   <= to_sel('0);
            r_busy  <= 1'b1;
          end
        end

        S_SCAN: begin
          if (w_dwell_end) r_sample[r_ch] <= i_mux_s;
          // Hold may arrive on any cycle; a capture on the same cycle still lands.
          if (i_hold) begin
            r_state <= S_HOLD;
            r_ch    <= w_hold_ch;
            r_cnt   <= '0;
            r_sel   <= to_sel(w_hold_ch);
          end else if (w_dwell_end) begin
            r_cnt <= '0;
            r_ch  <= w_ch_next;
            r_sel <= to_sel(w_ch_next);
            if (r_ch == LAST_CH) begin
              r_frame_done <= 1'b1;
              if (!i_enable) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_HOLD: begin
          if (w_dwell_end) r_sample[r_ch] <= i_mux_s;
          if (i_hold) begin
            r_ch  <= w_hold_ch;
            r_sel <= to_sel(w_hold_ch);
            r_cnt <= w_dwell_end ? '0 : r_cnt + CNT_W'(1);
          end else if (i_enable) begin
            r_state <= S_SCAN;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_sel   <= to_sel('0);
          end else begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_ch    <= '0;
          r_cnt   <= '0;
          r_sel   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sel        = r_sel;
  assign o_sample     = r_sample;
  assign o_frame_done = r_frame_done;
  assign o_busy       = r_busy;

endmodule
